scarv_cop_palu_arb: RTL and testbench

//  Arbitrates two requesters (decode issue port 0, microcode/sequence port 1)

---
 rtl/scarv_cop_palu_arb_if.sv | 40 ++++
 rtl/scarv_cop_palu_arb.sv | 150 +++++++++++++++
 tb/tb_scarv_cop_palu_arb.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_palu_arb_if.sv
// Bundle of request, PALU and response signals shared by the PALU arbiter
// and its environment. The slave view belongs to the arbiter; the master
// view belongs to whatever drives requests, models the PALU and consumes
// results.
interface scarv_cop_palu_arb_if #(
  parameter int unsigned OPW = 171
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic           flush;
  logic           palu_ivalid;
  logic [OPW-1:0] palu_op;
  logic           palu_idone;
  logic [3:0]     palu_ben;
  logic [31:0]    palu_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [3:0]     rsp_ben;
  logic [31:0]    rsp_wdata;
  logic           rsp_err;

  modport slave (
    input  req0_valid, req0_op, req1_valid, req1_op, flush,
           palu_idone, palu_ben, palu_wdata, rsp_ready,
    output req0_ready, req1_ready, palu_ivalid, palu_op,
           rsp_valid, rsp_id, rsp_ben, rsp_wdata, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req1_valid, req1_op, flush,
           palu_idone, palu_ben, palu_wdata, rsp_ready,
    input  req0_ready, req1_ready, palu_ivalid, palu_op,
           rsp_valid, rsp_id, rsp_ben, rsp_wdata, rsp_err
  );
endinterface

// File: rtl/scarv_cop_palu_arb.sv
// Round-robin arbiter placing two requesters onto the single shared PALU.
// The winning op bundle is registered and held with palu_ivalid high until
// the PALU signals done (or the watchdog aborts it); the captured result is
// then offered back to the owning port.
module scarv_cop_palu_arb #(
  parameter int unsigned OPW     = 171,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  scarv_cop_palu_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [OPW-1:0] r_op;
  logic           r_owner;
  logic           r_last_grant;
  logic [CW-1:0]  r_wdog;
  logic           r_flush_pend;
  logic           r_rsp_id;
  logic [3:0]     r_rsp_ben;
  logic [31:0]    r_rsp_wdata;
  logic           r_rsp_err;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_capture;
  logic           w_abort;
  logic           w_drop;

  // Next-state, grant selection and result-capture decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_drop      = bus.flush | r_flush_pend;
    case (r_state)
      ST_IDLE: begin
        // Port 0 wins unless port 1 is also waiting and port 0 went last.
        if (bus.req0_valid && (!bus.req1_valid || r_last_grant)) begin
          w_grant0 = 1'b1;
        end else if (bus.req1_valid) begin
          w_grant1 = 1'b1;
        end
        if (w_grant0 || w_grant1) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A flushed op still runs to completion so the multiplier is never
        // abandoned mid-operation; only its result is discarded.
        if (bus.palu_idone) begin
          if (w_drop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end else if (r_wdog == WDOG_LAST) begin
          if (w_drop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_abort     = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.flush || bus.rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Op bundle, ownership, watchdog, pending flush and response registers.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_op         <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wdog       <= '0;
      r_flush_pend <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_ben    <= '0;
      r_rsp_wdata  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_grant0 || w_grant1) begin
        r_op         <= w_grant1 ? bus.req1_op : bus.req0_op;
        r_owner      <= w_grant1;
        r_last_grant <= w_grant1;
        r_wdog       <= '0;
        r_flush_pend <= 1'b0;
      end
      if (r_state == ST_ISSUE) begin
        r_wdog <= r_wdog + CW'(1);
        if (bus.flush) begin
          r_flush_pend <= 1'b1;
        end
      end
      if (w_capture) begin
        r_rsp_id    <= r_owner;
        r_rsp_ben   <= bus.palu_ben;
        r_rsp_wdata <= bus.palu_wdata;
        r_rsp_err   <= 1'b0;
      end else if (w_abort) begin
        r_rsp_id    <= r_owner;
        r_rsp_ben   <= '0;
        r_rsp_wdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign bus.req0_ready  = w_grant0;
  assign bus.req1_ready  = w_grant1;
  assign bus.palu_ivalid = (r_state == ST_ISSUE);
  assign bus.palu_op     = r_op;
  assign bus.rsp_valid   = (r_state == ST_RESP);
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_ben     = r_rsp_ben;
  assign bus.rsp_wdata   = r_rsp_wdata;
  assign bus.rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_scarv_cop_palu_arb.sv
// Directed bench for the PALU arbiter: reset, single op, round-robin,
// multi-cycle op, watchdog abort, response back-pressure, flush and reset
// during issue. Inputs change on the falling edge; outputs are checked
// shortly after.
module tb_scarv_cop_palu_arb;

  localparam int unsigned OPW = 171;

  localparam logic [OPW-1:0] OP_A  = 171'h1_1111_2222_3333_4444_0000_0001;
  localparam logic [OPW-1:0] OP_B0 = 171'h2_AAAA_0000_BBBB_0000_0000_00B0;
  localparam logic [OPW-1:0] OP_B1 = 171'h3_0000_CCCC_0000_DDDD_0000_00B1;
  localparam logic [OPW-1:0] OP_M  = 171'h4_5555_6666_7777_8888_9999_0A0A;
  localparam logic [OPW-1:0] OP_T  = 171'h5_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  scarv_cop_palu_arb_if #(.OPW(OPW)) bus ();

  scarv_cop_palu_arb #(
    .OPW     (OPW),
    .TIMEOUT (8),
    .CW      (4)
  ) dut (
    .g_clk   (clk),
    .g_reset (rst),
    .bus     (bus)
  );

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op = '0; bus.req1_op = '0; bus.flush = 1'b0;
    bus.palu_idone = 1'b0; bus.palu_ben = '0; bus.palu_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (bus.palu_ivalid !== 1'b0) begin n_fail++; $display("FAIL reset_ivalid got %0b exp 0", bus.palu_ivalid); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
    n_chk++; if (bus.palu_op !== '0) begin n_fail++; $display("FAIL reset_palu_op got %h exp 0", bus.palu_op); end
    n_chk++; if ({bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err} !== 38'd0) begin n_fail++; $display("FAIL reset_rsp_fields got %h exp 0", {bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err}); end
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b exp 00", {bus.req0_ready, bus.req1_ready}); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.req0_op = OP_A; bus.req0_valid = 1'b1;
    bus.palu_idone = 1'b1; bus.palu_ben = 4'hF; bus.palu_wdata = 32'hCAFE_0001;
    bus.rsp_ready = 1'b0;
    #1;
    n_chk++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready got %b exp 10", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk); bus.req0_valid = 1'b0; #1;
    n_chk++; if (bus.palu_ivalid !== 1'b1) begin n_fail++; $display("FAIL single_ivalid got %0b exp 1", bus.palu_ivalid); end
    n_chk++; if (bus.palu_op !== OP_A) begin n_fail++; $display("FAIL single_op got %h exp %h", bus.palu_op, OP_A); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_early got %0b exp 0", bus.rsp_valid); end
    @(negedge clk); #1;
    n_chk++; if (bus.palu_ivalid !== 1'b0) begin n_fail++; $display("FAIL single_ivalid_drop got %0b exp 0", bus.palu_ivalid); end
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got %0b exp 1", bus.rsp_valid); end
    n_chk++; if ({bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err} !== {1'b0, 4'hF, 32'hCAFE_0001, 1'b0}) begin n_fail++; $display("FAIL single_rsp got id=%0b ben=%h wdata=%h err=%0b exp id=0 ben=f wdata=cafe0001 err=0", bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err); end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_release got %0b exp 0", bus.rsp_valid); end
    bus.rsp_ready = 1'b0; bus.palu_idone = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_id;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.req0_op = OP_B0; bus.req1_op = OP_B1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.rsp_ready = 1'b1; bus.palu_idone = 1'b1; bus.palu_wdata = 32'h2000_0000;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 1);
      #1;
      n_chk++; if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", k, {bus.req0_ready, bus.req1_ready}, {~exp_id, exp_id}); end
      @(negedge clk); #1;
      n_chk++; if (bus.palu_op !== (exp_id ? OP_B1 : OP_B0)) begin n_fail++; $display("FAIL rr_op[%0d] got %h exp %h", k, bus.palu_op, exp_id ? OP_B1 : OP_B0); end
      @(negedge clk); #1;
      n_chk++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, exp_id}) begin n_fail++; $display("FAIL rr_rsp[%0d] got valid=%0b id=%0b exp valid=1 id=%0b", k, bus.rsp_valid, bus.rsp_id, exp_id); end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b0; bus.palu_idone = 1'b0;
  endtask

  task automatic test_multicycle();
    bus.req0_op = OP_M; bus.req0_valid = 1'b1; bus.palu_idone = 1'b0;
    #1;
    n_chk++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready got %0b exp 1", bus.req0_ready); end
    @(negedge clk); bus.req0_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      n_chk++; if ({bus.palu_ivalid, bus.palu_op} !== {1'b1, OP_M}) begin n_fail++; $display("FAIL mul_issue[%0d] got ivalid=%0b op=%h exp ivalid=1 op=%h", c, bus.palu_ivalid, bus.palu_op, OP_M); end
      bus.palu_idone = (c == 5); bus.palu_ben = 4'h3; bus.palu_wdata = 32'h100 + c;
      @(negedge clk);
    end
    bus.palu_idone = 1'b0; #1;
    n_chk++; if ({bus.palu_ivalid, bus.rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL mul_state got ivalid=%0b rsp_valid=%0b exp 0 1", bus.palu_ivalid, bus.rsp_valid); end
    n_chk++; if ({bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err} !== {1'b0, 4'h3, 32'h105, 1'b0}) begin n_fail++; $display("FAIL mul_rsp got id=%0b ben=%h wdata=%h err=%0b exp id=0 ben=3 wdata=105 err=0", bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err); end
    bus.rsp_ready = 1'b1; @(negedge clk); bus.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bus.req1_op = OP_T; bus.req1_valid = 1'b1;
    bus.palu_idone = 1'b0; bus.palu_ben = 4'hF; bus.palu_wdata = 32'hFFFF_FFFF;
    #1;
    n_chk++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready got %0b exp 1", bus.req1_ready); end
    @(negedge clk); bus.req1_valid = 1'b0; #1;
    n = 0;
    while (bus.palu_ivalid && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    n_chk++; if (n != 8) begin n_fail++; $display("FAIL tmo_ivalid_cycles got %0d exp 8", n); end
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err} !== {1'b1, 1'b1, 4'h0, 32'h0, 1'b1}) begin n_fail++; $display("FAIL tmo_rsp got valid=%0b id=%0b ben=%h wdata=%h err=%0b exp 1 1 0 0 1", bus.rsp_valid, bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err); end
    bus.rsp_ready = 1'b1; @(negedge clk); bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    bus.req0_op = OP_A; bus.req0_valid = 1'b1;
    bus.palu_idone = 1'b1; bus.palu_ben = 4'h9; bus.palu_wdata = 32'h5A5A_0003;
    @(negedge clk); bus.req0_valid = 1'b0;
    @(negedge clk);
    bus.palu_wdata = 32'h0; bus.palu_ben = 4'h0;
    bus.req1_op = OP_B1; bus.req1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err, bus.req1_ready, bus.palu_ivalid} !== {1'b1, 1'b0, 4'h9, 32'h5A5A_0003, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL hold[%0d] got valid=%0b id=%0b ben=%h wdata=%h err=%0b rdy1=%0b ivalid=%0b exp 1 0 9 5a5a0003 0 0 0", c, bus.rsp_valid, bus.rsp_id, bus.rsp_ben, bus.rsp_wdata, bus.rsp_err, bus.req1_ready, bus.palu_ivalid); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %0b exp 1", bus.req1_ready); end
    @(negedge clk); bus.req1_valid = 1'b0; bus.palu_wdata = 32'h0000_0777;
    @(negedge clk); #1;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_wdata} !== {1'b1, 1'b1, 32'h0000_0777}) begin n_fail++; $display("FAIL hold_next_rsp got valid=%0b id=%0b wdata=%h exp 1 1 777", bus.rsp_valid, bus.rsp_id, bus.rsp_wdata); end
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.palu_idone = 1'b0;
  endtask

  task automatic test_flush_reset();
    bus.req0_op = OP_M; bus.req0_valid = 1'b1; bus.palu_idone = 1'b0;
    bus.palu_ben = 4'hF; bus.palu_wdata = 32'hDEAD_BEEF;
    @(negedge clk); bus.req0_valid = 1'b0;
    @(negedge clk); bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0; #1;
    n_chk++; if (bus.palu_ivalid !== 1'b1) begin n_fail++; $display("FAIL flush_runs_on got %0b exp 1", bus.palu_ivalid); end
    @(negedge clk); bus.palu_idone = 1'b1; #1;
    n_chk++; if (bus.palu_ivalid !== 1'b1) begin n_fail++; $display("FAIL flush_ivalid_c4 got %0b exp 1", bus.palu_ivalid); end
    @(negedge clk); bus.palu_idone = 1'b0; #1;
    n_chk++; if ({bus.rsp_valid, bus.palu_ivalid} !== 2'b00) begin n_fail++; $display("FAIL flush_no_rsp got rsp_valid=%0b ivalid=%0b exp 0 0", bus.rsp_valid, bus.palu_ivalid); end
    bus.req0_op = OP_A; bus.req0_valid = 1'b1; #1;
    n_chk++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready got %0b exp 1", bus.req0_ready); end
    @(negedge clk); bus.req0_valid = 1'b0; #1;
    n_chk++; if (bus.palu_ivalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ivalid got %0b exp 1", bus.palu_ivalid); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++; if ({bus.palu_ivalid, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_err} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got %b exp 00000", {bus.palu_ivalid, bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_err}); end
    n_chk++; if ({bus.palu_op, bus.rsp_ben, bus.rsp_wdata, bus.rsp_id} !== '0) begin n_fail++; $display("FAIL rst_mid_data got op=%h ben=%h wdata=%h id=%0b exp 0", bus.palu_op, bus.rsp_ben, bus.rsp_wdata, bus.rsp_id); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got no finish exp finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_multicycle();
    test_timeout();
    test_back_pressure();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
